// File: rtl/fetch_queue_pkg.sv
// Shared sizing and entry layout for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_CNT_W = 3;

  // One queued fetch: the PC and the instruction read at it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC/ROM stage and decode. The PC stage
// cannot stall, so when the queue is full and nothing drains, the incoming
// pair is dropped and a replay is requested, which the controller turns into
// a jump back to the same PC. A flush (taken jump) empties the queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int CNT_W = FQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic             flush_i,
  input  logic             deq_ready_i,
  output logic             deq_valid_o,
  output logic [31:0]      deq_pc_o,
  output logic [31:0]      deq_inst_o,
  output logic             replay_o,
  output logic [31:0]      replay_pc_o,
  output logic [CNT_W-1:0] count_o,
  output logic [15:0]      replay_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;

  // Handshake decode; a full queue still accepts when the head drains.
  assign full        = (count == CNT_W'(DEPTH));
  assign pop         = deq_valid_o & deq_ready_i;
  assign push        = !rst & !flush_i & (!full | pop);
  assign replay_o    = !rst & !flush_i & !push;
  assign replay_pc_o = pc_i;

  assign deq_valid_o = (count != '0);
  assign deq_pc_o    = mem[rd_ptr].pc;
  assign deq_inst_o  = mem[rd_ptr].inst;
  assign count_o     = count;

  // Entry storage; contents are not reset, validity lives in count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc_i, inst: inst_i};
  end

  // Pointers and occupancy; reset and flush both empty the queue and a
  // handshake in the flush cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating replay-cycle counter; survives flush, cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst)
      replay_cnt_o <= '0;
    else if (replay_o && replay_cnt_o != 16'hFFFF)
      replay_cnt_o <= replay_cnt_o + 16'd1;
  end

endmodule
